// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg: STAGES chained valid/ready skid slices carrying a WIDTH-bit payload.
// Optional stall counter output enabled by defining PIPE_ELASTIC_STALL_CNT_EN.
module pipe_elastic_reg #(
    parameter int WIDTH = 32,
    parameter int STAGES = 1,
    localparam int OCC_W = $clog2(2 * STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
`ifdef PIPE_ELASTIC_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;

    // link k is the input of slice k; link STAGES is the module output
    logic [STAGES:0]  link_v;
    logic [STAGES:0]  link_r;
    logic [WIDTH-1:0] link_d [STAGES+1];
    logic [STAGES-1:0] main_v;
    logic [STAGES-1:0] skid_v;

    assign link_v[0]      = in_valid;
    assign link_d[0]      = in_data;
    assign link_r[STAGES] = out_ready;
    assign in_ready       = link_r[0];
    assign out_valid      = link_v[STAGES];
    assign out_data       = link_d[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        state_t           state;
        state_t           state_nxt;
        logic [WIDTH-1:0] main_d;
        logic [WIDTH-1:0] skid_d;
        logic             in_fire;
        logic             out_fire;
        logic             load_main;
        logic             load_skid;

        assign main_v[k]     = state[0];
        assign skid_v[k]     = state[1];
        assign link_r[k]     = !state[1];
        assign link_v[k + 1] = state[0];
        assign link_d[k + 1] = main_d;
        assign in_fire       = link_v[k] & link_r[k];
        assign out_fire      = link_v[k + 1] & link_r[k + 1];

        always_comb begin
            state_nxt = state;
            load_main = 1'b0;
            load_skid = 1'b0;
            case (state)
                EMPTY: begin
                    state_nxt = in_fire ? ONE : EMPTY;
                    load_main = in_fire;
                end
                ONE: begin
                    state_nxt = (in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : ONE;
                    load_main = in_fire & out_fire;
                    load_skid = in_fire & !out_fire;
                end
                FULL: begin
                    state_nxt = out_fire ? ONE : FULL;
                    load_main = out_fire;
                end
                default: state_nxt = EMPTY;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                state  <= EMPTY;
                main_d <= '0;
                skid_d <= '0;
            end else begin
                state <= state_nxt;
                if (load_main)
                    main_d <= (state == FULL) ? skid_d : link_d[k];
                if (load_skid)
                    skid_d <= link_d[k];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++)
            occupancy = occupancy + OCC_W'(main_v[i]) + OCC_W'(skid_v[i]);
    end

`ifdef PIPE_ELASTIC_STALL_CNT_EN
    // flush deliberately leaves the count alone
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_elastic_reg.sv
// tb_pipe_elastic_reg: directed and scoreboarded checks on STAGES=1 and STAGES=2 instances.
module tb_pipe_elastic_reg;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;

    logic        f1, v1, rd1, ov1, or1;
    logic [31:0] d1, od1;
    logic [1:0]  occ1;
    logic        f2, v2, rd2, ov2, or2;
    logic [31:0] d2, od2;
    logic [2:0]  occ2;
`ifdef PIPE_ELASTIC_STALL_CNT_EN
    logic [31:0] sc1, sc2;
`endif

    pipe_elastic_reg #(.WIDTH(32), .STAGES(1)) u1 (
        .clk(clk), .reset(reset), .flush(f1), .in_valid(v1), .in_ready(rd1), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1)
`ifdef PIPE_ELASTIC_STALL_CNT_EN
        , .stall_cnt(sc1)
`endif
    );

    pipe_elastic_reg #(.WIDTH(32), .STAGES(2)) u2 (
        .clk(clk), .reset(reset), .flush(f2), .in_valid(v2), .in_ready(rd2), .in_data(d2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(occ2)
`ifdef PIPE_ELASTIC_STALL_CNT_EN
        , .stall_cnt(sc2)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        {f1, v1, or1, f2, v2, or2} = '0;
        d1 = '0;
        d2 = '0;
        tick();
        tick();
        vectors++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov1 got %b want 0", ov1); end
        vectors++; if (od1 !== 32'h0) begin errors++; $display("FAIL reset_od1 got %h want 0", od1); end
        vectors++; if (rd1 !== 1'b1) begin errors++; $display("FAIL reset_rd1 got %b want 1", rd1); end
        vectors++; if (occ1 !== 2'd0) begin errors++; $display("FAIL reset_occ1 got %0d want 0", occ1); end
        vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_ov2 got %b want 0", ov2); end
        vectors++; if (od2 !== 32'h0) begin errors++; $display("FAIL reset_od2 got %h want 0", od2); end
        vectors++; if (rd2 !== 1'b1) begin errors++; $display("FAIL reset_rd2 got %b want 1", rd2); end
        vectors++; if (occ2 !== 3'd0) begin errors++; $display("FAIL reset_occ2 got %0d want 0", occ2); end
        reset = 1'b0;
    endtask

    task automatic test_streaming;
        logic [31:0] din [5] = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0};
        logic        vin [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        e_ov [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] e_od [5] = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h33};
        logic [2:0]  e_occ [5] = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd0};
        or2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v2 = vin[i];
            d2 = din[i];
            tick();
            vectors++; if (ov2 !== e_ov[i]) begin errors++; $display("FAIL stream_ov[%0d] got %b want %b", i, ov2, e_ov[i]); end
            vectors++; if (od2 !== e_od[i]) begin errors++; $display("FAIL stream_od[%0d] got %h want %h", i, od2, e_od[i]); end
            vectors++; if (occ2 !== e_occ[i]) begin errors++; $display("FAIL stream_occ[%0d] got %0d want %0d", i, occ2, e_occ[i]); end
            vectors++; if (rd2 !== 1'b1) begin errors++; $display("FAIL stream_rd[%0d] got %b want 1", i, rd2); end
        end
    endtask

    task automatic test_backpressure;
        logic        s_or [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        s_v  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] s_d  [6] = '{32'hA, 32'hB, 32'hC, 32'hC, 32'hC, 32'h0};
        logic        e_rd [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        e_ov [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] e_od [6] = '{32'hA, 32'hA, 32'hA, 32'hB, 32'hC, 32'hC};
        logic [1:0]  e_occ [6] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        logic [31:0] got [$];
        for (int i = 0; i < 6; i++) begin
            or1 = s_or[i];
            v1 = s_v[i];
            d1 = s_d[i];
            if (ov1 && or1) got.push_back(od1);
            tick();
            vectors++; if (rd1 !== e_rd[i]) begin errors++; $display("FAIL bp_rd[%0d] got %b want %b", i, rd1, e_rd[i]); end
            vectors++; if (ov1 !== e_ov[i]) begin errors++; $display("FAIL bp_ov[%0d] got %b want %b", i, ov1, e_ov[i]); end
            vectors++; if (od1 !== e_od[i]) begin errors++; $display("FAIL bp_od[%0d] got %h want %h", i, od1, e_od[i]); end
            vectors++; if (occ1 !== e_occ[i]) begin errors++; $display("FAIL bp_occ[%0d] got %0d want %0d", i, occ1, e_occ[i]); end
        end
        vectors++;
        if (got.size() != 3 || got[0] !== 32'hA || got[1] !== 32'hB || got[2] !== 32'hC) begin
            errors++;
            $display("FAIL bp_order got %p want A,B,C", got);
        end
    endtask

    task automatic test_flush;
        logic [2:0] e_occ [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        or2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v2 = 1'b1;
            d2 = 32'(i + 1);
            tick();
            vectors++; if (occ2 !== e_occ[i]) begin errors++; $display("FAIL fill_occ[%0d] got %0d want %0d", i, occ2, e_occ[i]); end
        end
        vectors++; if (rd2 !== 1'b0) begin errors++; $display("FAIL full_rd got %b want 0", rd2); end
        f2 = 1'b1;
        d2 = 32'h55;
        tick();
        f2 = 1'b0;
        v2 = 1'b0;
        or2 = 1'b1;
        vectors++; if (occ2 !== 3'd0) begin errors++; $display("FAIL flush_occ got %0d want 0", occ2); end
        vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL flush_ov got %b want 0", ov2); end
        vectors++; if (od2 !== 32'h0) begin errors++; $display("FAIL flush_od got %h want 0", od2); end
        vectors++; if (rd2 !== 1'b1) begin errors++; $display("FAIL flush_rd got %b want 1", rd2); end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL flush_leak[%0d] got ov=%b od=%h want ov=0", i, ov2, od2); end
        end
    endtask

    task automatic test_reset_mid;
        or2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v2 = 1'b1;
            d2 = 32'h40 + 32'(i);
            tick();
        end
        reset = 1'b1;
        d2 = 32'h99;
        tick();
        vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL rmid_ov got %b want 0", ov2); end
        vectors++; if (od2 !== 32'h0) begin errors++; $display("FAIL rmid_od got %h want 0", od2); end
        vectors++; if (rd2 !== 1'b1) begin errors++; $display("FAIL rmid_rd got %b want 1", rd2); end
        vectors++; if (occ2 !== 3'd0) begin errors++; $display("FAIL rmid_occ got %0d want 0", occ2); end
        reset = 1'b0;
        d2 = 32'h77;
        tick();
        v2 = 1'b0;
        vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL rmid_early got %b want 0", ov2); end
        tick();
        vectors++; if (ov2 !== 1'b1) begin errors++; $display("FAIL rmid_late_ov got %b want 1", ov2); end
        vectors++; if (od2 !== 32'h77) begin errors++; $display("FAIL rmid_late_od got %h want 77", od2); end
        tick();
    endtask

    task automatic test_random;
        logic [31:0] q1 [$];
        logic [31:0] q2 [$];
        logic        fi1, fo1, hold1, fi2, fo2, hold2;
        logic [31:0] in1, in2, pod1, pod2;
        for (int n = 0; n < 3040; n++) begin
            v1 = (n < 3000) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
            or1 = (n < 3000) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            d1 = $urandom;
            v2 = (n < 3000) ? 1'($urandom_range(0, 2) != 0) : 1'b0;
            or2 = (n < 3000) ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            d2 = $urandom;
            fi1 = v1 & rd1;
            fo1 = ov1 & or1;
            hold1 = ov1 & !or1;
            in1 = d1;
            pod1 = od1;
            fi2 = v2 & rd2;
            fo2 = ov2 & or2;
            hold2 = ov2 & !or2;
            in2 = d2;
            pod2 = od2;
            tick();
            if (fo1) begin
                vectors++;
                if (q1.size() == 0 || pod1 !== q1[0]) begin errors++; $display("FAIL rnd1_data cyc %0d got %h want %h", n, pod1, (q1.size() != 0) ? q1[0] : 32'hx); end
                if (q1.size() != 0) void'(q1.pop_front());
            end
            if (fi1) q1.push_back(in1);
            if (fo2) begin
                vectors++;
                if (q2.size() == 0 || pod2 !== q2[0]) begin errors++; $display("FAIL rnd2_data cyc %0d got %h want %h", n, pod2, (q2.size() != 0) ? q2[0] : 32'hx); end
                if (q2.size() != 0) void'(q2.pop_front());
            end
            if (fi2) q2.push_back(in2);
            vectors++; if (int'(occ1) != q1.size()) begin errors++; $display("FAIL rnd1_occ cyc %0d got %0d want %0d", n, occ1, q1.size()); end
            vectors++; if (int'(occ2) != q2.size()) begin errors++; $display("FAIL rnd2_occ cyc %0d got %0d want %0d", n, occ2, q2.size()); end
            if (hold1) begin
                vectors++; if (ov1 !== 1'b1 || od1 !== pod1) begin errors++; $display("FAIL rnd1_hold cyc %0d got %b/%h want 1/%h", n, ov1, od1, pod1); end
            end
            if (hold2) begin
                vectors++; if (ov2 !== 1'b1 || od2 !== pod2) begin errors++; $display("FAIL rnd2_hold cyc %0d got %b/%h want 1/%h", n, ov2, od2, pod2); end
            end
        end
        vectors++; if (q1.size() != 0 || ov1 !== 1'b0) begin errors++; $display("FAIL rnd1_drain got %0d left want 0", q1.size()); end
        vectors++; if (q2.size() != 0 || ov2 !== 1'b0) begin errors++; $display("FAIL rnd2_drain got %0d left want 0", q2.size()); end
    endtask

`ifdef PIPE_ELASTIC_STALL_CNT_EN
    task automatic test_stall_cnt;
        test_reset();
        or1 = 1'b0;
        v1 = 1'b1;
        d1 = 32'h5A;
        tick();
        v1 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        vectors++; if (sc1 !== 32'd5) begin errors++; $display("FAIL stall_cnt got %0d want 5", sc1); end
        f1 = 1'b1;
        or1 = 1'b1;
        tick();
        f1 = 1'b0;
        vectors++; if (ov1 !== 1'b0) begin errors++; $display("FAIL stall_flush_ov got %b want 0", ov1); end
        tick();
        tick();
        vectors++; if (sc1 !== 32'd5) begin errors++; $display("FAIL stall_after_flush got %0d want 5", sc1); end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_reset();
        test_random();
`ifdef PIPE_ELASTIC_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
